multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
// - Multicycle successor to the single-cycle MIPS controller; sequences one instruction over FETCH/DECODE/EXEC/MEM/WB.
// - Memory handshakes stretch FETCH and MEM, so the datapath can share one memory port.
// - Adds an illegal-opcode trap and a memory-timeout trap.
// - Sits between InstructionFetchUnit/DataMemory and the RegisterFile/ALU32Bit datapath muxes.
// PARAMETERS
// - MEM_TIMEOUT  15  max wait cycles on MemReady/InstrValid before the timeout trap (1..255)
// - ENABLE_EXT   1   1: CLO/CLZ/ROTR/ROTRV/MOVZ/MUL legal; 0: treated as illegal
// - ALUCTRL_W    4   ALUControl width
// PORTS
// - Clk           in   1          clock, rising edge
// - Reset         in   1          synchronous, active-high
// - Instruction   in   32         instruction word from fetch path
// - InstrValid    in   1          Instruction valid this cycle (FETCH handshake)
// - MemReady      in   1          data memory completed the read/write (MEM handshake)
// - Zero          in   1          ALU zero flag
// - ALUResultLSB  in   1          ALUResult[0], used by BLTZ/BGEZ/BGTZ
// - IRWrite       out  1          latch Instruction into the IR
// - PCWrite       out  1          unconditional PC update (sequential or jump)
// - BranchTaken   out  1          conditional PC update to the branch target
// - Jump, JumpSel out  1 each     jump enable; 0 = target from instr[25:0], 1 = target from rs
// - ALUControl    out  ALUCTRL_W  AND0 OR1 ADD2 NOR3 XOR4 SUB6 SLT7 MUL9 SLL10 GTZ11 CLx12 ROTR13
// - ALUASrc       out  1          ALU A-input select
// - ALUBSrc       out  3          ALU B-input select
// - RegDst        out  2          0 rt, 1 rd, 2 $31
// - RegDataSel    out  2          register write-data select
// - ExtendSign    out  1          sign-extend the immediate
// - MemRead, MemWrite, MemtoReg  out  1 each
// - RegWrite      out  1          single-cycle pulse, WB only; for MOVZ gated by Zero
// - Trap          out  1          sticky trap flag
// - TrapCause     out  2          0 none, 1 illegal opcode/funct, 2 memory timeout
// - State         out  3          debug view of the current state
// BEHAVIOUR
// - States (3-bit): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
// - Reset: state=FETCH, wait counter=0, IR=0; every output 0 except MemRead=1 (FETCH request).
// - FETCH
//   - MemRead=1.
//   - On InstrValid: IRWrite=1 and PCWrite=1 for exactly that cycle, then go to DECODE.
//   - Otherwise the counter increments; reaching MEM_TIMEOUT -> TRAP, cause 2.
// - DECODE: classify the IR.
//   - IR==0 (NOP) -> FETCH.
//   - Undefined opcode/funct, or an extension op with ENABLE_EXT=0 -> TRAP, cause 1.
//   - Otherwise -> EXEC.
// - EXEC: ALU controls driven per the opcode table.
//   - BEQ: BranchTaken=Zero. BNE: BranchTaken=~Zero.
//   - BLTZ/BGTZ: BranchTaken=ALUResultLSB. BGEZ: BranchTaken=~ALUResultLSB.
//   - J/JR: Jump=1 and PCWrite=1.
//   - Branches, J and JR -> FETCH. LW/SW -> MEM. All other ops -> WB; JAL also asserts Jump+PCWrite.
// - MEM: MemRead (LW) or MemWrite (SW) held until MemReady.
//   - MemReady: LW -> WB, SW -> FETCH.
//   - Counter reaches MEM_TIMEOUT -> TRAP, cause 2; MemWrite drops on the same cycle.
// - WB: RegWrite=1 for exactly one cycle (MOVZ: RegWrite=Zero), then -> FETCH.
//   - JAL writes PC+4 to $31: RegDst=2, RegDataSel=1. LW: MemtoReg=1.
// - TRAP: all enables 0, Trap=1, TrapCause held; leaves only on Reset.
// - Latency (zero wait states): R/I-type 4 cycles, LW 5, SW 4, branch/jump 3, NOP 2.
// - Wait counter clears on every state entry; a handshake on the last allowed cycle (count==MEM_TIMEOUT-1) succeeds.
// - Reset has priority over any handshake and clears mid-MEM accesses; no write completes after Reset.
// - Outputs are Moore-decoded from state+IR. The only Mealy terms are BranchTaken (Zero/ALUResultLSB) and the IRWrite/PCWrite/RegWrite handshake qualifiers.
// STRUCTURE
// - Shared package mips_ctrl_pkg holds opcode/funct localparams, ALUControl codes, state and TrapCause encodings.
// - One sub-module, instr_class_decode: combinational IR -> class (RTYPE, IMM, LOAD, STORE, BRANCH, JUMP, EXT, NOP, ILLEGAL) plus per-class datapath controls.
// - The FSM, wait counter and IR register stay in this module.
// TESTING
// - ADD $3,$1,$2 (0x00221820), InstrValid at cycle 1:
//   -> states FETCH, DECODE, EXEC, WB; ALUControl=2, RegDst=1; RegWrite exactly 1 cycle in WB.
// - LW $2,4($1) (0x8C220004) with MemReady after 3 wait cycles:
//   -> MEM lasts 4 cycles, MemRead held throughout; WB with MemtoReg=1, RegDst=0.
// - BEQ (0x10220003) with Zero=1, then Zero=0:
//   -> BranchTaken=1 in EXEC then FETCH; second case BranchTaken=0; RegWrite never asserted.
// - Opcode 0x3F, and CLZ with ENABLE_EXT=0:
//   -> TRAP, TrapCause=1, all enables 0; stays until Reset, then state=FETCH.
// - SW with MemReady never asserted, MEM_TIMEOUT=15:
//   -> TRAP after exactly 15 MEM cycles, TrapCause=2, MemWrite deasserted the same cycle.
// - Reset asserted during MEM of SW:
//   -> next cycle state=FETCH, MemWrite=0, MemRead=1, Trap=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, trap causes,
// opcode/funct fields, ALU operation codes and the decoded-instruction record.
package mips_ctrl_pkg;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE    = 6'h05, OP_BGTZ = 6'h07, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI   = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E, OP_SPECIAL2 = 6'h1C, OP_LW = 6'h23, OP_SW   = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRLV = 6'h06, F_JR   = 6'h08;
    localparam logic [5:0] F_MOVZ = 6'h0A, F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27, F_SLT  = 6'h2A;
    localparam logic [5:0] F2_MUL = 6'h02, F2_CLZ = 6'h20, F2_CLO = 6'h21;

    localparam logic [3:0] ALU_AND = 4'd0,  ALU_OR  = 4'd1,  ALU_ADD = 4'd2,  ALU_NOR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4,  ALU_SUB = 4'd6,  ALU_SLT = 4'd7,  ALU_MUL  = 4'd9;
    localparam logic [3:0] ALU_SLL = 4'd10, ALU_GTZ = 4'd11, ALU_CLX = 4'd12, ALU_ROTR = 4'd13;

    localparam logic [2:0] BSRC_REG = 3'd0, BSRC_IMM = 3'd1, BSRC_SHAMT = 3'd2;
    localparam logic [2:0] BSRC_ZERO = 3'd3, BSRC_RS = 3'd4;

    typedef enum logic [3:0] {
        CLS_RTYPE, CLS_IMM, CLS_LOAD, CLS_STORE, CLS_BRANCH,
        CLS_JUMP, CLS_EXT, CLS_NOP, CLS_ILLEGAL
    } instrClassE;

    typedef enum logic [1:0] {BR_EQ, BR_NE, BR_LSB, BR_NLSB} branchKindE;

    typedef struct packed {
        instrClassE cls;
        logic [3:0] aluCtrl;
        logic       aluASrc;     // 0 rs, 1 rt
        logic [2:0] aluBSrc;
        logic [1:0] regDst;
        logic [1:0] regDataSel;  // 0 ALU, 1 PC+4, 2 rs
        logic       extendSign;
        branchKindE brKind;
        logic       jumpSel;
        logic       link;
        logic       condWrite;
    } decodeCtrlS;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Controller <-> fetch/memory/datapath signal bundle; master is the controller side.
interface multicycle_control_fsm_if #(parameter int ALUCTRL_W = 4);
    // Handshakes: a request (MemRead in FETCH, MemRead/MemWrite in MEM) stays
    // asserted until the responder raises InstrValid/MemReady for one cycle;
    // the transfer completes on the rising edge where both are high.
    logic [31:0]          Instruction;
    logic                 InstrValid, MemReady, Zero, ALUResultLSB;
    logic                 IRWrite, PCWrite, BranchTaken, Jump, JumpSel;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 ALUASrc;
    logic [2:0]           ALUBSrc;
    logic [1:0]           RegDst, RegDataSel;
    logic                 ExtendSign, MemRead, MemWrite, MemtoReg, RegWrite, Trap;
    logic [1:0]           TrapCause;
    logic [2:0]           State;

    modport master (
        input  Instruction, InstrValid, MemReady, Zero, ALUResultLSB,
        output IRWrite, PCWrite, BranchTaken, Jump, JumpSel, ALUControl, ALUASrc,
               ALUBSrc, RegDst, RegDataSel, ExtendSign, MemRead, MemWrite,
               MemtoReg, RegWrite, Trap, TrapCause, State
    );
    modport slave (
        output Instruction, InstrValid, MemReady, Zero, ALUResultLSB,
        input  IRWrite, PCWrite, BranchTaken, Jump, JumpSel, ALUControl, ALUASrc,
               ALUBSrc, RegDst, RegDataSel, ExtendSign, MemRead, MemWrite,
               MemtoReg, RegWrite, Trap, TrapCause, State
    );
endinterface

// File: rtl/instr_class_decode.sv
// Combinational IR classifier: instruction class plus the per-class datapath selects.
module instr_class_decode
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output decodeCtrlS  ctrl
);
    logic [5:0] opcode, funct;
    logic [4:0] rt;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign rt     = instr[20:16];

    always_comb begin
        ctrl     = '0;
        ctrl.cls = CLS_ILLEGAL;
        if (instr == 32'd0) begin
            ctrl.cls = CLS_NOP;
        end else begin
            case (opcode)
                OP_RTYPE: begin
                    ctrl.cls    = CLS_RTYPE;
                    ctrl.regDst = 2'd1;
                    case (funct)
                        F_ADD, F_ADDU: ctrl.aluCtrl = ALU_ADD;
                        F_SUB, F_SUBU: ctrl.aluCtrl = ALU_SUB;
                        F_AND:         ctrl.aluCtrl = ALU_AND;
                        F_OR:          ctrl.aluCtrl = ALU_OR;
                        F_XOR:         ctrl.aluCtrl = ALU_XOR;
                        F_NOR:         ctrl.aluCtrl = ALU_NOR;
                        F_SLT:         ctrl.aluCtrl = ALU_SLT;
                        F_SLL: begin
                            ctrl.aluCtrl = ALU_SLL;
                            ctrl.aluASrc = 1'b1;
                            ctrl.aluBSrc = BSRC_SHAMT;
                        end
                        // Plain SRL/SRLV have no ALU code; only their rotate forms are accepted.
                        F_SRL, F_SRLV: begin
                            ctrl.cls     = ((funct == F_SRL) ? instr[21] : instr[6]) ? CLS_EXT : CLS_ILLEGAL;
                            ctrl.aluCtrl = ALU_ROTR;
                            ctrl.aluASrc = 1'b1;
                            ctrl.aluBSrc = (funct == F_SRL) ? BSRC_SHAMT : BSRC_RS;
                        end
                        F_JR: begin
                            ctrl.cls     = CLS_JUMP;
                            ctrl.regDst  = 2'd0;
                            ctrl.jumpSel = 1'b1;
                        end
                        // MOVZ: ALU passes rt through so Zero reports rt==0; rs is the write data.
                        F_MOVZ: begin
                            ctrl.cls        = CLS_EXT;
                            ctrl.aluCtrl    = ALU_OR;
                            ctrl.aluASrc    = 1'b1;
                            ctrl.aluBSrc    = BSRC_ZERO;
                            ctrl.regDataSel = 2'd2;
                            ctrl.condWrite  = 1'b1;
                        end
                        default: ctrl.cls = CLS_ILLEGAL;
                    endcase
                end
                OP_SPECIAL2: begin
                    ctrl.regDst = 2'd1;
                    case (funct)
                        F2_MUL:         begin ctrl.cls = CLS_EXT; ctrl.aluCtrl = ALU_MUL; end
                        F2_CLZ, F2_CLO: begin ctrl.cls = CLS_EXT; ctrl.aluCtrl = ALU_CLX; end
                        default:        ctrl.cls = CLS_ILLEGAL;
                    endcase
                end
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                    ctrl.cls        = CLS_IMM;
                    ctrl.aluBSrc    = BSRC_IMM;
                    ctrl.extendSign = (opcode == OP_ADDI) || (opcode == OP_ADDIU) || (opcode == OP_SLTI);
                    case (opcode)
                        OP_SLTI: ctrl.aluCtrl = ALU_SLT;
                        OP_ANDI: ctrl.aluCtrl = ALU_AND;
                        OP_ORI:  ctrl.aluCtrl = ALU_OR;
                        OP_XORI: ctrl.aluCtrl = ALU_XOR;
                        default: ctrl.aluCtrl = ALU_ADD;
                    endcase
                end
                OP_LW, OP_SW: begin
                    ctrl.cls        = (opcode == OP_LW) ? CLS_LOAD : CLS_STORE;
                    ctrl.aluCtrl    = ALU_ADD;
                    ctrl.aluBSrc    = BSRC_IMM;
                    ctrl.extendSign = 1'b1;
                end
                OP_BEQ, OP_BNE: begin
                    ctrl.cls     = CLS_BRANCH;
                    ctrl.aluCtrl = ALU_SUB;
                    ctrl.brKind  = (opcode == OP_BEQ) ? BR_EQ : BR_NE;
                end
                OP_REGIMM: begin
                    ctrl.cls     = (rt == 5'd0 || rt == 5'd1) ? CLS_BRANCH : CLS_ILLEGAL;
                    ctrl.aluCtrl = ALU_SLT;
                    ctrl.aluBSrc = BSRC_ZERO;
                    ctrl.brKind  = (rt == 5'd0) ? BR_LSB : BR_NLSB;
                end
                OP_BGTZ: begin
                    ctrl.cls     = CLS_BRANCH;
                    ctrl.aluCtrl = ALU_GTZ;
                    ctrl.aluBSrc = BSRC_ZERO;
                    ctrl.brKind  = BR_LSB;
                end
                OP_J:   ctrl.cls = CLS_JUMP;
                OP_JAL: begin
                    ctrl.cls        = CLS_JUMP;
                    ctrl.link       = 1'b1;
                    ctrl.regDst     = 2'd2;
                    ctrl.regDataSel = 2'd1;
                end
                default: ctrl.cls = CLS_ILLEGAL;
            endcase
        end
    end
endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a shared
// memory port, illegal-instruction trap and memory-timeout trap.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int ENABLE_EXT  = 1,
    parameter int ALUCTRL_W   = 4
) (
    input logic Clk,
    input logic Reset,
    multicycle_control_fsm_if.master bus
);
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0]  state, stateNext;
    logic [1:0]  trapCause, trapCauseNext;
    logic [7:0]  waitCnt;
    logic [31:0] ir;
    decodeCtrlS  dec;
    logic        illegal, waitExpired, isLoad, isStore, aluActive;

    instr_class_decode uDecode (.instr(ir), .ctrl(dec));

    assign illegal     = (dec.cls == CLS_ILLEGAL) || ((dec.cls == CLS_EXT) && (ENABLE_EXT == 0));
    assign waitExpired = (waitCnt == WAIT_LAST);
    assign isLoad      = (dec.cls == CLS_LOAD);
    assign isStore     = (dec.cls == CLS_STORE);
    assign aluActive   = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

    always_comb begin
        stateNext     = state;
        trapCauseNext = trapCause;
        case (state)
            S_FETCH: begin
                if (bus.InstrValid) stateNext = S_DECODE;
                else if (waitExpired) begin
                    stateNext     = S_TRAP;
                    trapCauseNext = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (dec.cls == CLS_NOP) stateNext = S_FETCH;
                else if (illegal) begin
                    stateNext     = S_TRAP;
                    trapCauseNext = CAUSE_ILLEGAL;
                end else stateNext = S_EXEC;
            end
            S_EXEC: begin
                case (dec.cls)
                    CLS_BRANCH:          stateNext = S_FETCH;
                    CLS_JUMP:            stateNext = dec.link ? S_WB : S_FETCH;
                    CLS_LOAD, CLS_STORE: stateNext = S_MEM;
                    default:             stateNext = S_WB;
                endcase
            end
            // MemReady wins over the timeout on the last allowed cycle.
            S_MEM: begin
                if (bus.MemReady) stateNext = isLoad ? S_WB : S_FETCH;
                else if (waitExpired) begin
                    stateNext     = S_TRAP;
                    trapCauseNext = CAUSE_TIMEOUT;
                end
            end
            S_WB:    stateNext = S_FETCH;
            S_TRAP:  stateNext = S_TRAP;
            default: stateNext = S_FETCH;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_FETCH;
            trapCause <= CAUSE_NONE;
            waitCnt   <= 8'd0;
            ir        <= 32'd0;
        end else begin
            state     <= stateNext;
            trapCause <= trapCauseNext;
            if (stateNext != state) waitCnt <= 8'd0;
            else if (state == S_FETCH || state == S_MEM) waitCnt <= waitCnt + 8'd1;
            if (state == S_FETCH && bus.InstrValid) ir <= bus.Instruction;
        end
    end

    always_comb begin
        bus.IRWrite     = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.BranchTaken = 1'b0;
        bus.Jump        = 1'b0;
        bus.JumpSel     = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 2'd0;
        bus.RegDataSel  = 2'd0;
        bus.ALUControl  = aluActive ? ALUCTRL_W'(dec.aluCtrl) : '0;
        bus.ALUASrc     = aluActive & dec.aluASrc;
        bus.ALUBSrc     = aluActive ? dec.aluBSrc : 3'd0;
        bus.ExtendSign  = aluActive & dec.extendSign;
        bus.Trap        = (state == S_TRAP);
        bus.TrapCause   = trapCause;
        bus.State       = state;
        case (state)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.IRWrite = bus.InstrValid;
                bus.PCWrite = bus.InstrValid;
            end
            S_EXEC: begin
                if (dec.cls == CLS_BRANCH) begin
                    case (dec.brKind)
                        BR_EQ:   bus.BranchTaken = bus.Zero;
                        BR_NE:   bus.BranchTaken = ~bus.Zero;
                        BR_LSB:  bus.BranchTaken = bus.ALUResultLSB;
                        default: bus.BranchTaken = ~bus.ALUResultLSB;
                    endcase
                end
                if (dec.cls == CLS_JUMP) begin
                    bus.Jump    = 1'b1;
                    bus.PCWrite = 1'b1;
                    bus.JumpSel = dec.jumpSel;
                end
            end
            S_MEM: begin
                bus.MemRead  = isLoad;
                bus.MemWrite = isStore;
            end
            S_WB: begin
                bus.RegWrite   = dec.condWrite ? bus.Zero : 1'b1;
                bus.RegDst     = dec.regDst;
                bus.RegDataSel = dec.regDataSel;
                bus.MemtoReg   = isLoad;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm; two instances share stimulus, one
// with extensions enabled (busA) and one with them disabled (busB).
module tb_multicycle_control_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        instrValid = 1'b0, memReady = 1'b0, zero = 1'b0, aluLsb = 1'b0;
    int          nCompared = 0;
    int          nMismatched = 0;

    multicycle_control_fsm_if #(.ALUCTRL_W(4)) busA ();
    multicycle_control_fsm_if #(.ALUCTRL_W(4)) busB ();

    assign busA.Instruction = instr;      assign busB.Instruction = instr;
    assign busA.InstrValid = instrValid;  assign busB.InstrValid = instrValid;
    assign busA.MemReady = memReady;      assign busB.MemReady = memReady;
    assign busA.Zero = zero;              assign busB.Zero = zero;
    assign busA.ALUResultLSB = aluLsb;    assign busB.ALUResultLSB = aluLsb;

    multicycle_control_fsm #(.MEM_TIMEOUT(15), .ENABLE_EXT(1), .ALUCTRL_W(4))
        dutA (.Clk(clk), .Reset(rst), .bus(busA));
    multicycle_control_fsm #(.MEM_TIMEOUT(15), .ENABLE_EXT(0), .ALUCTRL_W(4))
        dutB (.Clk(clk), .Reset(rst), .bus(busB));

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        instrValid = 1'b0;
        memReady = 1'b0;
        nextCycle();
        rst = 1'b0;
        #1;
        checkVal("rst_state", {29'd0, busA.State}, 32'd0);
        checkVal("rst_trap", {31'd0, busA.Trap}, 32'd0);
    endtask

    // Leaves the DUT in DECODE, 2 time units after the edge.
    task automatic fetchInstr(input string tag, input logic [31:0] word);
        instr = word;
        instrValid = 1'b1;
        #1;
        checkVal({tag, "_irwrite"}, {31'd0, busA.IRWrite}, 32'd1);
        checkVal({tag, "_pcwrite"}, {31'd0, busA.PCWrite}, 32'd1);
        nextCycle();
        instrValid = 1'b0;
        instr = 32'hDEAD_BEEF;
        #1;
        checkVal({tag, "_decode"}, {29'd0, busA.State}, 32'd1);
        checkVal({tag, "_dec_irwrite"}, {31'd0, busA.IRWrite}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset values
        nextCycle();
        nextCycle();
        checkVal("reset_state", {29'd0, busA.State}, 32'd0);
        checkVal("reset_memread", {31'd0, busA.MemRead}, 32'd1);
        checkVal("reset_regwrite", {31'd0, busA.RegWrite}, 32'd0);
        checkVal("reset_memwrite", {31'd0, busA.MemWrite}, 32'd0);
        checkVal("reset_alu", {28'd0, busA.ALUControl}, 32'd0);
        checkVal("reset_trap", {30'd0, busA.TrapCause}, 32'd0);
        rst = 1'b0;
        #1;

        // ADD $3,$1,$2
        fetchInstr("add", 32'h0022_1820);
        nextCycle();
        checkVal("add_exec", {29'd0, busA.State}, 32'd2);
        checkVal("add_alu", {28'd0, busA.ALUControl}, 32'd2);
        checkVal("add_exec_regwrite", {31'd0, busA.RegWrite}, 32'd0);
        nextCycle();
        checkVal("add_wb", {29'd0, busA.State}, 32'd4);
        checkVal("add_regwrite", {31'd0, busA.RegWrite}, 32'd1);
        checkVal("add_regdst", {30'd0, busA.RegDst}, 32'd1);
        nextCycle();
        checkVal("add_fetch", {29'd0, busA.State}, 32'd0);
        checkVal("add_regwrite_off", {31'd0, busA.RegWrite}, 32'd0);

        // LW $2,4($1), MemReady after 3 wait cycles
        fetchInstr("lw", 32'h8C22_0004);
        nextCycle();
        checkVal("lw_exec_bsrc", {29'd0, busA.ALUBSrc}, 32'd1);
        checkVal("lw_exec_sext", {31'd0, busA.ExtendSign}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            nextCycle();
            if (k == 4) memReady = 1'b1;
            #1;
            checkVal($sformatf("lw_mem%0d_state", k), {29'd0, busA.State}, 32'd3);
            checkVal($sformatf("lw_mem%0d_memread", k), {31'd0, busA.MemRead}, 32'd1);
        end
        nextCycle();
        memReady = 1'b0;
        #1;
        checkVal("lw_wb", {29'd0, busA.State}, 32'd4);
        checkVal("lw_memtoreg", {31'd0, busA.MemtoReg}, 32'd1);
        checkVal("lw_regdst", {30'd0, busA.RegDst}, 32'd0);
        checkVal("lw_regwrite", {31'd0, busA.RegWrite}, 32'd1);
        nextCycle();
        checkVal("lw_fetch", {29'd0, busA.State}, 32'd0);

        // BEQ, taken then not taken
        for (int t = 0; t < 2; t++) begin
            fetchInstr("beq", 32'h1022_0003);
            nextCycle();
            zero = (t == 0);
            #1;
            checkVal($sformatf("beq%0d_exec", t), {29'd0, busA.State}, 32'd2);
            checkVal($sformatf("beq%0d_taken", t), {31'd0, busA.BranchTaken}, (t == 0) ? 32'd1 : 32'd0);
            checkVal($sformatf("beq%0d_alu", t), {28'd0, busA.ALUControl}, 32'd6);
            checkVal($sformatf("beq%0d_regwrite", t), {31'd0, busA.RegWrite}, 32'd0);
            nextCycle();
            zero = 1'b0;
            #1;
            checkVal($sformatf("beq%0d_fetch", t), {29'd0, busA.State}, 32'd0);
            checkVal($sformatf("beq%0d_regwrite2", t), {31'd0, busA.RegWrite}, 32'd0);
        end

        // NOP: FETCH, DECODE, back to FETCH
        fetchInstr("nop", 32'h0000_0000);
        nextCycle();
        checkVal("nop_fetch", {29'd0, busA.State}, 32'd0);

        // JAL: jump in EXEC, link write in WB
        fetchInstr("jal", 32'h0C00_0010);
        nextCycle();
        checkVal("jal_jump", {31'd0, busA.Jump}, 32'd1);
        checkVal("jal_pcwrite", {31'd0, busA.PCWrite}, 32'd1);
        checkVal("jal_jumpsel", {31'd0, busA.JumpSel}, 32'd0);
        nextCycle();
        checkVal("jal_wb", {29'd0, busA.State}, 32'd4);
        checkVal("jal_regdst", {30'd0, busA.RegDst}, 32'd2);
        checkVal("jal_regdatasel", {30'd0, busA.RegDataSel}, 32'd1);
        nextCycle();

        // Illegal opcode 0x3F: trap is sticky until reset
        fetchInstr("ill", 32'hFC00_0000);
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            instrValid = 1'b1;
            #1;
            checkVal($sformatf("ill%0d_state", k), {29'd0, busA.State}, 32'd7);
            checkVal($sformatf("ill%0d_cause", k), {30'd0, busA.TrapCause}, 32'd1);
            checkVal($sformatf("ill%0d_trap", k), {31'd0, busA.Trap}, 32'd1);
            checkVal($sformatf("ill%0d_memread", k), {31'd0, busA.MemRead}, 32'd0);
            checkVal($sformatf("ill%0d_pcwrite", k), {31'd0, busA.PCWrite}, 32'd0);
        end
        applyReset();
        checkVal("ill_rst_cause", {30'd0, busA.TrapCause}, 32'd0);

        // CLZ $2,$1: legal with extensions, trap without
        fetchInstr("clz", 32'h7022_1020);
        nextCycle();
        checkVal("clz_a_exec", {29'd0, busA.State}, 32'd2);
        checkVal("clz_a_alu", {28'd0, busA.ALUControl}, 32'd12);
        checkVal("clz_b_state", {29'd0, busB.State}, 32'd7);
        checkVal("clz_b_cause", {30'd0, busB.TrapCause}, 32'd1);
        checkVal("clz_b_memread", {31'd0, busB.MemRead}, 32'd0);
        nextCycle();
        checkVal("clz_a_wb", {29'd0, busA.State}, 32'd4);
        checkVal("clz_b_hold", {29'd0, busB.State}, 32'd7);
        applyReset();
        checkVal("clz_b_rst", {29'd0, busB.State}, 32'd0);

        // SW with MemReady on the last allowed cycle succeeds, then SW timeout
        for (int t = 0; t < 2; t++) begin
            fetchInstr("sw", 32'hAC22_0004);
            nextCycle();
            for (int k = 1; k <= 15; k++) begin
                nextCycle();
                if (t == 0 && k == 15) memReady = 1'b1;
                #1;
                checkVal($sformatf("sw%0d_mem%0d_state", t, k), {29'd0, busA.State}, 32'd3);
                checkVal($sformatf("sw%0d_mem%0d_memwrite", t, k), {31'd0, busA.MemWrite}, 32'd1);
            end
            nextCycle();
            memReady = 1'b0;
            #1;
            checkVal($sformatf("sw%0d_after_state", t), {29'd0, busA.State}, (t == 0) ? 32'd0 : 32'd7);
            checkVal($sformatf("sw%0d_after_memwrite", t), {31'd0, busA.MemWrite}, 32'd0);
            checkVal($sformatf("sw%0d_after_cause", t), {30'd0, busA.TrapCause}, (t == 0) ? 32'd0 : 32'd2);
        end
        applyReset();

        // Reset in the middle of an SW access
        fetchInstr("swrst", 32'hAC22_0004);
        nextCycle();
        nextCycle();
        nextCycle();
        checkVal("swrst_mem", {31'd0, busA.MemWrite}, 32'd1);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        #1;
        checkVal("swrst_state", {29'd0, busA.State}, 32'd0);
        checkVal("swrst_memwrite", {31'd0, busA.MemWrite}, 32'd0);
        checkVal("swrst_memread", {31'd0, busA.MemRead}, 32'd1);
        checkVal("swrst_trap", {31'd0, busA.Trap}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
